// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB control FSM for an RV32I-subset multicycle datapath.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions; otherwise they retire as NOPs.
module multicycle_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        iReady,
    input  logic        dReady,
    input  logic        Zero,
    output logic [31:0] instrOut,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        loadPC,
    output logic [3:0]  ALUCtrl,
    output logic        MemRead,
    output logic        MemWrite,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic        illegal,
`endif
    output logic [2:0]  state
);
    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                           ALU_XOR = 4'b0100, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111,
                           ALU_SRL = 4'b1000, ALU_SLL = 4'b1001, ALU_SRA = 4'b1010;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_HALT = 3'd5,
`endif
        S_WB  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir;
    logic        zero_q;
    logic [3:0]  func_op, alu_op;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic        alt, is_r, is_i, r_ok, i_ok, is_lw, is_sw, is_beq, is_mem, exec;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign f7     = ir[31:25];
    assign alt    = f7 == 7'b0100000;
    assign is_r   = opcode == 7'b0110011;
    assign is_i   = opcode == 7'b0010011;
    assign is_lw  = opcode == 7'b0000011 && f3 == 3'b010;
    assign is_sw  = opcode == 7'b0100011 && f3 == 3'b010;
    assign is_beq = opcode == 7'b1100011 && f3 == 3'b000;
    assign is_mem = is_lw || is_sw;
    // funct3=011 (SLTU/SLTIU) has no ALU code, so it is rejected along with bad funct7 patterns
    assign r_ok   = is_r && f3 != 3'b011 &&
                    (f7 == 7'd0 || (alt && (f3 == 3'b000 || f3 == 3'b101)));
    assign i_ok   = is_i && f3 != 3'b011 &&
                    (f3 == 3'b001 ? f7 == 7'd0 : f3 == 3'b101 ? (f7 == 7'd0 || alt) : 1'b1);

    always_comb begin
        case (f3)
            3'b000:  func_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  func_op = ALU_SLL;
            3'b010:  func_op = ALU_SLT;
            3'b100:  func_op = ALU_XOR;
            3'b101:  func_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  func_op = ALU_OR;
            default: func_op = ALU_AND;
        endcase
    end

    assign alu_op = is_beq ? ALU_SUB : (r_ok || i_ok) ? func_op : ALU_ADD;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    state_d = iReady ? S_ID : S_IF;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ID:    state_d = (r_ok || i_ok || is_mem || is_beq) ? S_EX : S_HALT;
            S_HALT:  state_d = S_HALT;
`else
            S_ID:    state_d = S_EX;
`endif
            S_EX:    state_d = S_MEM;
            S_MEM:   state_d = (is_mem && !dReady) ? S_MEM : S_WB;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF;
            ir      <= NOP_INSTR;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF && iReady) ir <= instr;
            if (state_q == S_EX) zero_q <= Zero;
        end
    end

    // all outputs are Moore-decoded, so async reset clears them without a clock edge
    assign exec     = state_q == S_EX || state_q == S_MEM || state_q == S_WB;
    assign instrOut = ir;
    assign state    = state_q;
    assign ALUSrc   = exec && (i_ok || is_mem);
    assign ALUCtrl  = exec ? alu_op : 4'b0000;
    assign MemRead  = state_q == S_MEM && is_lw;
    assign MemWrite = state_q == S_MEM && is_sw;
    assign MemToReg = (state_q == S_MEM || state_q == S_WB) && is_lw;
    assign RegWrite = state_q == S_WB && (r_ok || i_ok || is_lw) && ir[11:7] != 5'd0;
    assign loadPC   = state_q == S_WB;
    assign PCSrc    = state_q == S_WB && is_beq && zero_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal  = state_q == S_HALT;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of the multicycle control FSM.
// Honours CTRL_ILLEGAL_TRAP_EN for the illegal-instruction scenario.
module tb_multicycle_ctrl;
    logic        clk, rst, iReady, dReady, Zero;
    logic [31:0] instr, instrOut;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic [14:0] ctl;
    int          total = 0, bad = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .iReady(iReady), .dReady(dReady), .Zero(Zero),
        .instrOut(instrOut), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .loadPC(loadPC), .ALUCtrl(ALUCtrl), .MemRead(MemRead),
        .MemWrite(MemWrite),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .state(state)
    );

    // {state, PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, ALUCtrl}
    assign ctl = {state, PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, ALUCtrl};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (ctl !== 15'd0) begin bad++; $display("FAIL reset_ctl got=%h exp=%h", ctl, 15'd0); end
        total++; if (instrOut !== 32'h00000013) begin bad++; $display("FAIL reset_ir got=%h exp=%h", instrOut, 32'h00000013); end
        tick();
        rst = 1; iReady = 0; instr = 32'h002081B3;
        tick();
        tick();
        total++; if (ctl !== 15'd0) begin bad++; $display("FAIL stall_if got=%h exp=%h", ctl, 15'd0); end
        iReady = 1;
        tick();
        tick();
        total++; if (ctl !== {3'd2, 7'b0000000, 4'b0010}) begin bad++; $display("FAIL pre_rst_ex got=%h exp=%h", ctl, {3'd2, 7'b0000000, 4'b0010}); end
        #2 rst = 0;
        #1;
        total++; if (ctl !== 15'd0) begin bad++; $display("FAIL async_rst_ctl got=%h exp=%h", ctl, 15'd0); end
        total++; if (instrOut !== 32'h00000013) begin bad++; $display("FAIL async_rst_ir got=%h exp=%h", instrOut, 32'h00000013); end
        #1 rst = 1;
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL rst_release_id got=%0d exp=%0d", state, 1); end
        total++; if (instrOut !== 32'h002081B3) begin bad++; $display("FAIL rst_release_ir got=%h exp=%h", instrOut, 32'h002081B3); end
        repeat (4) tick();
        total++; if (ctl !== 15'd0) begin bad++; $display("FAIL rst_back_if got=%h exp=%h", ctl, 15'd0); end
    endtask

    task automatic test_add();
        logic [14:0] ev [6];
        ev = '{15'd0, {3'd1, 11'd0}, {3'd2, 7'b0000000, 4'b0010}, {3'd3, 7'b0000000, 4'b0010},
               {3'd4, 7'b0010100, 4'b0010}, 15'd0};
        instr = 32'h002081B3; iReady = 1; dReady = 0;
        for (int c = 0; c < 6; c++) begin
            total++; if (ctl !== ev[c]) begin bad++; $display("FAIL add_c%0d got=%h exp=%h", c, ctl, ev[c]); end
            if (c == 1) instr = 32'hDEADBEEF;
            if (c < 5) tick();
        end
        total++; if (instrOut !== 32'h002081B3) begin bad++; $display("FAIL add_ir_hold got=%h exp=%h", instrOut, 32'h002081B3); end
    endtask

    task automatic test_lw_sw();
        logic [14:0] ev [9];
        logic [14:0] es [7];
        ev = '{15'd0, {3'd1, 11'd0}, {3'd2, 7'b0100000, 4'b0010},
               {3'd3, 7'b0101010, 4'b0010}, {3'd3, 7'b0101010, 4'b0010},
               {3'd3, 7'b0101010, 4'b0010}, {3'd3, 7'b0101010, 4'b0010},
               {3'd4, 7'b0111100, 4'b0010}, 15'd0};
        instr = 32'h0080A283;
        for (int c = 0; c < 9; c++) begin
            dReady = (c == 6);
            total++; if (ctl !== ev[c]) begin bad++; $display("FAIL lw_c%0d got=%h exp=%h", c, ctl, ev[c]); end
            if (c < 8) tick();
        end
        es = '{15'd0, {3'd1, 11'd0}, {3'd2, 7'b0100000, 4'b0010},
               {3'd3, 7'b0100001, 4'b0010}, {3'd3, 7'b0100001, 4'b0010},
               {3'd4, 7'b0100100, 4'b0010}, 15'd0};
        instr = 32'h0020A223;
        for (int c = 0; c < 7; c++) begin
            dReady = (c == 4);
            total++; if (ctl !== es[c]) begin bad++; $display("FAIL sw_c%0d got=%h exp=%h", c, ctl, es[c]); end
            if (c < 6) tick();
        end
        dReady = 0;
    endtask

    task automatic test_beq(input logic z);
        logic [14:0] ev [6];
        ev = '{15'd0, {3'd1, 11'd0}, {3'd2, 7'b0000000, 4'b0110}, {3'd3, 7'b0000000, 4'b0110},
               {3'd4, z, 6'b000100, 4'b0110}, 15'd0};
        instr = 32'h00208463;
        for (int c = 0; c < 6; c++) begin
            Zero = (c == 2) ? z : ~z;
            total++; if (ctl !== ev[c]) begin bad++; $display("FAIL beq_z%0d_c%0d got=%h exp=%h", z, c, ctl, ev[c]); end
            if (c < 5) tick();
        end
        Zero = 0;
    endtask

    task automatic test_imm();
        logic [14:0] ev [6];
        ev = '{15'd0, {3'd1, 11'd0}, {3'd2, 7'b0100000, 4'b1010}, {3'd3, 7'b0100000, 4'b1010},
               {3'd4, 7'b0110100, 4'b1010}, 15'd0};
        instr = 32'h40325213;
        for (int c = 0; c < 6; c++) begin
            total++; if (ctl !== ev[c]) begin bad++; $display("FAIL srai_c%0d got=%h exp=%h", c, ctl, ev[c]); end
            if (c < 5) tick();
        end
        ev = '{15'd0, {3'd1, 11'd0}, {3'd2, 7'b0100000, 4'b0010}, {3'd3, 7'b0100000, 4'b0010},
               {3'd4, 7'b0100100, 4'b0010}, 15'd0};
        instr = 32'h00500013;
        for (int c = 0; c < 6; c++) begin
            total++; if (ctl !== ev[c]) begin bad++; $display("FAIL addi_x0_c%0d got=%h exp=%h", c, ctl, ev[c]); end
            if (c < 5) tick();
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] iv [8];
        logic [4:0]  ev [8];
        iv = '{32'h403100B3, 32'h0010C093, 32'h003160B3, 32'h003120B3,
               32'h003150B3, 32'h00209093, 32'h0070F093, 32'h403150B3};
        ev = '{5'b00110, 5'b10100, 5'b00001, 5'b00111, 5'b01000, 5'b11001, 5'b10000, 5'b01010};
        for (int k = 0; k < 8; k++) begin
            instr = iv[k];
            tick();
            tick();
            total++; if ({ALUSrc, ALUCtrl} !== ev[k]) begin bad++; $display("FAIL alu_op%0d got=%b exp=%b", k, {ALUSrc, ALUCtrl}, ev[k]); end
            repeat (3) tick();
        end
    endtask

    task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
        instr = 32'hFFFFFFFF; dReady = 1;
        tick();
        total++; if (ctl !== {3'd1, 11'd0}) begin bad++; $display("FAIL ill_id got=%h exp=%h", ctl, {3'd1, 11'd0}); end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (ctl !== {3'd5, 11'd0}) begin bad++; $display("FAIL halt_c%0d got=%h exp=%h", c, ctl, {3'd5, 11'd0}); end
            total++; if (illegal !== 1'b1) begin bad++; $display("FAIL halt_flag_c%0d got=%b exp=1", c, illegal); end
        end
        rst = 0;
        #1;
        total++; if (ctl !== 15'd0 || illegal !== 1'b0) begin bad++; $display("FAIL halt_rst got=%h/%b exp=0/0", ctl, illegal); end
        rst = 1;
`else
        logic [14:0] ev [6];
        ev = '{15'd0, {3'd1, 11'd0}, {3'd2, 7'b0000000, 4'b0010}, {3'd3, 7'b0000000, 4'b0010},
               {3'd4, 7'b0000100, 4'b0010}, 15'd0};
        instr = 32'hFFFFFFFF; dReady = 0;
        for (int c = 0; c < 6; c++) begin
            total++; if (ctl !== ev[c]) begin bad++; $display("FAIL ill_nop_c%0d got=%h exp=%h", c, ctl, ev[c]); end
            if (c < 5) tick();
        end
`endif
    endtask

    initial begin
        rst = 1; iReady = 0; dReady = 0; Zero = 0; instr = 32'd0;
        #1 rst = 0;
        test_reset();
        test_add();
        test_lw_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_imm();
        test_alu_ops();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control unit sitting directly upstream of the processor datapath.
- Fetches and latches each instruction, decodes the RV32I subset the datapath supports, and sequences IF→ID→EX→MEM→WB.
- Drives the datapath control lines PCSrc, ALUSrc, RegWrite, MemToReg, loadPC and ALUCtrl, plus the memory strobes.
- Waits on ready handshakes from instruction and data memory.

Parameters:
- NOP_INSTR, 32'h00000013, value loaded into the instruction register on reset (ADDI x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- instr  input  32  instruction word from instruction memory at current PC.
- iReady  input  1  instruction memory has valid data on instr.
- dReady  input  1  data memory read/write completed this cycle.
- Zero  input  1  ALU zero flag from the datapath.
- instrOut  output  32  latched instruction (IR) presented to the datapath.
- PCSrc  output  1  select branch target for PC update.
- ALUSrc  output  1  ALU op2 select: immediate (1) or register (0).
- RegWrite  output  1  register file write enable.
- MemToReg  output  1  write-back select: memory (1) or ALU (0).
- loadPC  output  1  PC update enable.
- ALUCtrl  output  4  ALU operation code.
- MemRead  output  1  data memory read strobe.
- MemWrite  output  1  data memory write strobe.
- state  output  3  current FSM state, for debug.

Behaviour:
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4 (HALT=5 only with the optional feature).
- Transitions:
  - IF→ID when iReady=1; IR<=instr on that edge. Stay in IF while iReady=0.
  - ID→EX and EX→MEM take one cycle each, unconditionally.
  - MEM→WB: LW/SW wait until dReady=1. Any other instruction leaves after one cycle and ignores dReady.
  - WB→IF takes one cycle.
- Latency: 5 cycles per instruction with no wait states.
- Reset (rst=0, asynchronous):
  - state=IF, IR=NOP_INSTR, zero_q=0.
  - All control outputs 0 and ALUCtrl=4'b0000 immediately, without waiting for a clock edge.
  - Reset mid-instruction abandons the instruction: no RegWrite, loadPC or MemWrite.
- Output decode (Moore, from state plus IR):
  - ALUSrc and ALUCtrl are valid in EX, MEM and WB, and 0 in IF and ID.
  - MemRead=1 in MEM for LW, held across the wait. MemWrite=1 in MEM for SW, held across the wait.
  - MemToReg=1 in MEM and WB for LW.
  - RegWrite=1 only in WB, for R-type, I-ALU and LW. It is forced 0 when rd=x0.
  - loadPC=1 only in WB, for exactly one cycle per instruction.
  - zero_q is captured from Zero on the EX→MEM edge. PCSrc=1 in WB iff the instruction is BEQ and zero_q=1.
- ALUCtrl encoding:
  - AND=0000, OR=0001, ADD=0010, XOR=0100, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010.
- Decode rules:
  - opcode 0110011 (R-type): funct3/funct7 select the op. SUB when funct3=000 and funct7[5]=1. SRA when funct3=101 and funct7[5]=1. ALUSrc=0.
  - opcode 0010011 (I-ALU): ADDI, SLTI, XORI, ORI, ANDI, SLLI, SRLI, SRAI. SRAI when funct7[5]=1. ALUSrc=1.
  - opcode 0000011 with funct3=010 (LW): ADD, ALUSrc=1.
  - opcode 0100011 with funct3=010 (SW): ADD, ALUSrc=1.
  - opcode 1100011 with funct3=000 (BEQ): SUB, ALUSrc=0.
- Any other encoding is illegal. Handling is defined under Optional Feature.
- instrOut=IR at all times, so instr may change after IF without affecting the datapath.

Optional Feature:
Macro CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal IR moves ID→HALT.
  - HALT is absorbing: all control outputs are 0 and state=5 until reset.
  - An extra output `illegal` (1 bit) is 1 in HALT and 0 otherwise.
- Not defined:
  - An illegal instruction behaves as a NOP: full IF..WB sequence, ALUCtrl=ADD, no RegWrite, no memory strobes, loadPC=1 in WB with PCSrc=0.
  - No `illegal` port exists.

Test Plan:
- Reset: rst=0 mid-EX of an ADD → state=0, all controls 0 and instrOut=32'h00000013 in the same cycle. Release rst with iReady=1 → ID on the next edge.
- ADD x3,x1,x2 (32'h002081B3), iReady tied 1 → ALUCtrl=0010 and ALUSrc=0 in EX. RegWrite=1 and loadPC=1 only in the WB cycle. Total 5 cycles.
- LW x5,8(x1) (32'h0080A283) with dReady low 3 cycles → MEM held 4 cycles with MemRead=1. MemToReg=1 in WB. Total 8 cycles.
- BEQ x1,x2 (32'h00208463):
  - Zero=1 in EX → PCSrc=1 with loadPC=1 in WB.
  - Zero=0 → PCSrc=0.
- SRAI x4,x4,3 (32'h40325213) → ALUCtrl=1010, ALUSrc=1. ADDI x0,x0,5 → RegWrite stays 0 in WB.
- Instruction 32'hFFFFFFFF:
  - With CTRL_ILLEGAL_TRAP_EN → state=5 and illegal=1, held until reset.
  - Without → NOP sequence, loadPC=1 in WB.
